// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed 7-segment display driver with frame-synchronised updates,
// dead-time anti-ghosting and optional leading-zero blanking.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 1000,
    parameter int DEAD_CLKS      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    input  logic                    i_blank,
    input  logic                    i_lzb,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_dig,
    output logic                    o_frame
);

    localparam int DW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [DW-1:0] DWELL_MAX = DW'(CLKS_PER_DIGIT - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] DEAD      = DW'(DEAD_CLKS);

    logic [VW-1:0]         r_pend_val;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic [VW-1:0]         r_disp_val;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [DW-1:0]         r_dwell;
    logic [IW-1:0]         r_idx;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic                  r_frame;

    logic                  w_wrap;
    logic                  w_last;
    logic [VW-1:0]         w_src_val;
    logic [NUM_DIGITS-1:0] w_src_dp;
    logic [VW-1:0]         w_cur_val;
    logic [NUM_DIGITS-1:0] w_cur_dp;
    logic [NUM_DIGITS-1:0] w_lzmask;
    logic                  w_run;
    logic [3:0]            w_nib;
    logic                  w_dpb;
    logic                  w_lzcur;
    logic [7:0]            w_lit;
    logic [NUM_DIGITS-1:0] w_dig;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign w_wrap    = (r_dwell == DWELL_MAX);
    assign w_last    = w_wrap && (r_idx == IDX_MAX);
    assign w_src_val = i_load ? i_value : r_pend_val;
    assign w_src_dp  = i_load ? i_dp : r_pend_dp;
    // On the frame cycle the first slot already renders the incoming value.
    assign w_cur_val = r_frame ? w_src_val : r_disp_val;
    assign w_cur_dp  = r_frame ? w_src_dp : r_disp_dp;

    always_comb begin
        w_run    = 1'b1;
        w_lzmask = '0;
        w_nib    = 4'h0;
        w_dpb    = 1'b0;
        w_lzcur  = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            w_run = w_run && (w_cur_val[4*d +: 4] == 4'h0) && !w_cur_dp[d];
            w_lzmask[d] = w_run && (d != 0) && i_lzb;
        end
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (IW'(d) == r_idx) begin
                w_nib   = w_cur_val[4*d +: 4];
                w_dpb   = w_cur_dp[d];
                w_lzcur = w_lzmask[d];
            end
        end
    end

    always_comb begin
        w_lit = {w_dpb, (w_lzcur ? 7'h00 : glyph(w_nib))};
        w_dig = NUM_DIGITS'(1) << r_idx;
        if (i_blank || (r_dwell < DEAD)) w_dig = '0;
        if (i_blank) w_lit = 8'h00;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_dwell    <= '0;
            r_idx      <= '0;
            r_seg      <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
            r_dig      <= DIG_ACTIVE_LOW ? '1 : '0;
            r_frame    <= 1'b0;
        end else begin
            if (i_load) begin
                r_pend_val <= i_value;
                r_pend_dp  <= i_dp;
            end
            if (r_frame) begin
                r_disp_val <= w_src_val;
                r_disp_dp  <= w_src_dp;
            end
            r_dwell <= w_wrap ? '0 : r_dwell + DW'(1);
            if (w_wrap) r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            r_seg   <= SEG_ACTIVE_LOW ? ~w_lit : w_lit;
            r_dig   <= DIG_ACTIVE_LOW ? ~w_dig : w_dig;
            r_frame <= w_last;
        end
    end

    assign o_seg   = r_seg;
    assign o_dig   = r_dig;
    assign o_frame = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux: vector table plus hand sequences
// for reset, load bypass, blanking and mid-frame reset.
module tb_seven_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val = '0;
    logic [3:0]  dp  = '0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic        lzb = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic            lzb;
        logic [3:0][7:0] seg;
    } vec_t;

    vec_t tbl[7];

    seven_seg_scan_mux #(
        .NUM_DIGITS(4), .CLKS_PER_DIGIT(8), .DEAD_CLKS(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_value(val), .i_dp(dp),
        .i_load(load), .i_blank(blank), .i_lzb(lzb),
        .o_seg(seg), .o_dig(dig), .o_frame(frame)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic sync_frame(input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (frame === 1'b1) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s no o_frame within 40 cycles", nm);
        end
    endtask

    task automatic period(input string nm);
        int n = 0;
        sync_frame(nm);
        do begin
            tick();
            n++;
        end while (frame !== 1'b1 && n < 40);
        chk(nm, 8'(n), 8'd32);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        tbl[1] = '{16'h0005, 4'b0010, 1'b1, {8'hFF, 8'hFF, 8'h40, 8'h92}};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        tbl[3] = '{16'h00A0, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h88, 8'hC0}};
        tbl[4] = '{16'hF00E, 4'b1000, 1'b0, {8'h0E, 8'hC0, 8'hC0, 8'h86}};
        tbl[5] = '{16'h0000, 4'b0100, 1'b1, {8'hFF, 8'h40, 8'hC0, 8'hC0}};
        tbl[6] = '{16'h8976, 4'b0000, 1'b1, {8'h80, 8'h90, 8'hF8, 8'h82}};

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_seg", seg, 8'hFF);
            chk("rst_dig", 8'(dig), 8'h0F);
            chk("rst_frame", 8'(frame), 8'h00);
        end
        rst = 1'b0;
        tick();
        chk("c0_dig", 8'(dig), 8'h0F);
        chk("c0_seg", seg, 8'hC0);
        tick(2);
        chk("c2_dig", 8'(dig), 8'h0E);
        chk("c2_seg", seg, 8'hC0);

        // mid-frame load stays hidden until the boundary
        tick(8);
        val  = 16'h1234;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick(15);
        chk("midload_d3_seg", seg, 8'hC0);
        chk("midload_d3_dig", 8'(dig), 8'h07);
        sync_frame("sync_a");
        tick(3);
        chk("nf_d0_seg", seg, 8'h99);
        tick(24);
        chk("nf_d3_seg", seg, 8'hF9);
        chk("nf_d3_dig", 8'(dig), 8'h07);
        period("period_a");

        // load on the o_frame cycle bypasses pending
        val  = 16'hABCD;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick(2);
        chk("byp_d0_seg", seg, 8'hA1);
        tick(8);
        chk("byp_d1_seg", seg, 8'hC6);
        chk("byp_d1_dig", 8'(dig), 8'h0D);

        // blank pulse for 5 cycles
        sync_frame("sync_b");
        tick(3);
        chk("pre_blank_seg", seg, 8'hA1);
        chk("pre_blank_dig", 8'(dig), 8'h0E);
        blank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("blank_seg", seg, 8'hFF);
            chk("blank_dig", 8'(dig), 8'h0F);
            if (i == 4) blank = 1'b0;
        end
        tick();
        chk("post_blank_seg", seg, 8'hC6);
        chk("post_blank_dead", 8'(dig), 8'h0F);
        tick(2);
        chk("post_blank_dig", 8'(dig), 8'h0D);
        period("period_blank");

        // vector table
        foreach (tbl[k]) begin
            val  = tbl[k].val;
            dp   = tbl[k].dp;
            lzb  = tbl[k].lzb;
            load = 1'b1;
            tick();
            load = 1'b0;
            sync_frame("sync_tbl");
            tick(3);
            for (int d = 0; d < 4; d++) begin
                logic [3:0] ed;
                ed = ~(4'b0001 << d);
                chk($sformatf("tbl%0d_d%0d_seg", k, d), seg, tbl[k].seg[d]);
                chk($sformatf("tbl%0d_d%0d_dig", k, d), 8'(dig), 8'(ed));
                if (d < 3) tick(8);
            end
        end

        // reset in slot 2 after a load
        lzb = 1'b0;
        dp  = 4'b0000;
        val = 16'h0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        sync_frame("sync_c");
        tick(17);
        val  = 16'h5555;
        load = 1'b1;
        tick();
        load = 1'b0;
        rst  = 1'b1;
        tick();
        chk("mrst_seg", seg, 8'hFF);
        chk("mrst_dig", 8'(dig), 8'h0F);
        chk("mrst_frame", 8'(frame), 8'h00);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_c0_dig", 8'(dig), 8'h0F);
        tick(2);
        chk("mrst_c2_dig", 8'(dig), 8'h0E);
        chk("mrst_c2_seg", seg, 8'hC0);
        sync_frame("sync_d");
        tick(3);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("mrst_nf_d%0d_seg", d), seg, 8'hC0);
            if (d < 3) tick(8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_mux.md
# seven_seg_scan_mux

Time-multiplexed driver for a multi-digit common-anode/common-cathode 7-segment display bank. Converts a packed hexadecimal value into per-digit segment patterns and scans the digits one at a time with programmable dwell and anti-ghosting dead time. Updates are frame-synchronised to prevent tearing. Digits can optionally suppress leading zeros. Sits between system logic (counters, status registers) and the board's segment/digit-select pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8
- CLKS_PER_DIGIT, 1000, clock cycles per digit slot; must be > DEAD_CLKS
- DEAD_CLKS, 2, cycles at the start of each slot where all digit selects are inactive; legal range 0..CLKS_PER_DIGIT-1
- SEG_ACTIVE_LOW, 1, 1 = segment is lit when its o_seg bit is 0
- DIG_ACTIVE_LOW, 1, 1 = digit is enabled when its o_dig bit is 0
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous and active-high
- i_value  in  4*NUM_DIGITS  packed nibbles; [3:0] is digit 0 (rightmost, least significant)
- i_dp  in  NUM_DIGITS  per-digit decimal point request
- i_load  in  1  capture i_value/i_dp into the pending register this cycle
- i_blank  in  1  blank the entire display (level, live, not frame-synchronised)
- i_lzb  in  1  leading-zero blanking enable (level, live)
- o_seg  out  8  segment drive; bit 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle, 7 dp
- o_dig  out  NUM_DIGITS  digit select, one-hot active (polarity per DIG_ACTIVE_LOW)
- o_frame  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1's slot

## Operation
- Glyphs (lit segment bits, polarity-neutral, hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. The physical output is inverted when SEG_ACTIVE_LOW=1. Digit selects are inverted when DIG_ACTIVE_LOW=1.
- Registers:
  - pending: value and dp. Loaded on i_load.
  - display: value and dp. Loaded only on the o_frame cycle, using display <= i_load ? {i_value,i_dp} : pending. A simultaneous load bypasses pending.
  - dwell counter 0..CLKS_PER_DIGIT-1.
  - digit index 0..NUM_DIGITS-1.
- Scan: the dwell counter increments every cycle. On wrap, the digit index increments, wrapping from NUM_DIGITS-1 to 0. Scan order is 0,1,…,NUM_DIGITS-1.
- Within a slot:
  - Dwell < DEAD_CLKS: all o_dig inactive. o_seg already shows the current digit's pattern.
  - Otherwise: only the current digit is active.
- Leading-zero blanking (i_lzb=1):
  - Scanning from digit NUM_DIGITS-1 downward, a digit is blanked (segments 0-6 unlit) while its nibble is 0 and no dp is set at that digit or any higher digit.
  - Digit 0 is never blanked.
  - Blanking stops at the first nonzero nibble or the first set dp, so 0x0005 with dp[1]=1 shows " 0.5".
  - A blanked digit still shows its own dp bit.
- i_blank=1: all o_seg bits unlit and all o_dig inactive. Counters keep running, so the frame cadence is unaffected.
- Reset (all outputs registered):
  - o_seg all unlit (0xFF if SEG_ACTIVE_LOW), o_dig all inactive, o_frame=0.
  - Counters, pending and display cleared to 0.
  - Reset mid-frame aborts the scan immediately; no partial update survives.

## Timing
- Cycle numbering: cycle 0 is the first rising edge with i_rst low.
- Slot k occupies cycles k*CLKS_PER_DIGIT .. (k+1)*CLKS_PER_DIGIT-1. Frame length is NUM_DIGITS*CLKS_PER_DIGIT.
- Outputs are registered. The o_seg/o_dig values for a given (index, dwell) appear one cycle after the counters reach that state. o_frame is aligned with the o_seg/o_dig of the last cycle of slot NUM_DIGITS-1.
- i_load to visible: the new value appears at the first slot of the next frame. Worst-case latency is one frame plus one cycle.
- i_blank and i_lzb take effect one cycle after they change.
- NUM_DIGITS=1: the index stays at 0, and o_frame pulses once per CLKS_PER_DIGIT cycles.
- DEAD_CLKS=0: there is no dead time and the digit is active for the whole slot.

## Test plan
Parameters: NUM_DIGITS=4, CLKS_PER_DIGIT=8, DEAD_CLKS=2, both polarities active-low.

- Reset held 3 cycles, then released with i_lzb=0 -> o_seg=0xFF and o_dig=0xF during reset. Afterwards each slot shows 0xC0 ("0"). o_dig=0xF in dead cycles, then 0xE/0xD/0xB/0x7. o_frame is high once every 32 cycles.
- i_load=1 with i_value=0x1234, mid-frame -> the display is unchanged until the frame boundary. Next frame, digit 0 shows 0x99 ("4") and digit 3 shows 0xF9 ("1").
- i_load on the exact o_frame cycle with 0xABCD, while pending holds 0x1234 -> the next frame shows ABCD (bypass). Digit 1 shows 0xC6 ("C").
- i_lzb=1, value 0x0005, dp=0b0010 -> digit 3 and digit 2 show 0xFF, digit 1 shows 0x40 ("0."), digit 0 shows 0x92. Then set value 0x0000, dp=0 -> only digit 0 is lit.
- i_blank pulsed for 5 cycles mid-slot -> o_seg=0xFF and o_dig=0xF for exactly those cycles (+1 latency). o_frame period stays at 32.
- i_rst asserted in slot 2 after an i_load -> outputs reset on the next edge. After release the scan restarts at digit 0, and the pending value is discarded (displays 0).
